// File: rtl/bcd_timer_control.sv
// bcd_timer_control
// Two-digit BCD up/down timer feeding the seven-segment display controller.
// Three raw push-buttons are synchronized and debounced; their rising edges
// drive an IDLE/RUN/PAUSE/DONE state machine that steps the count once per
// prescaled tick.
`timescale 1ns/1ps

module bcd_timer_control #(
    parameter int CLOCKS_PER_TICK = 4,
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       BTN_START,
    input  logic       BTN_CLEAR,
    input  logic       BTN_LOAD,
    input  logic       UP_DOWN,
    input  logic [7:0] PRESET,
    output logic [7:0] num,
    output logic       RUNNING,
    output logic       DONE
);

    localparam int PW = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLOCKS_PER_TICK - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // BCD increment, wrapping 99 -> 00 (never reached while running up).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] >= 4'd9) ? 4'd0 : (v[7:4] + 4'd1);
        end else begin
            r[3:0] = v[3:0] + 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // BCD decrement, wrapping 00 -> 99 (never reached while running down).
    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd0) begin
            r[3:0] = 4'd9;
            r[7:4] = (v[7:4] == 4'd0) ? 4'd9 : (v[7:4] - 4'd1);
        end else begin
            r[3:0] = v[3:0] - 4'd1;
            r[7:4] = v[7:4];
        end
        return r;
    endfunction

    // Limit each digit of a preset to 9 so num is always valid BCD.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
        logic [7:0] r;
        r[7:4] = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        r[3:0] = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return r;
    endfunction

    // Button bit order: [0]=START, [1]=CLEAR, [2]=LOAD
    logic [2:0]         w_raw;
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         r_deb;
    logic [2:0]         r_deb_d;
    logic [2:0][CW-1:0] r_cnt;
    logic [2:0]         w_evt;
    logic               w_start;
    logic               w_clear;
    logic               w_load;

    state_t             r_state;
    state_t             w_state_nx;
    logic [7:0]         r_num;
    logic [7:0]         w_num_nx;
    logic [PW-1:0]      r_pre;
    logic [PW-1:0]      w_pre_nx;
    logic               r_dir;
    logic               w_dir_nx;
    logic               r_running;
    logic               r_done;
    logic [7:0]         w_step;
    logic               w_tick;
    logic               w_term_hit;

    assign w_raw   = {BTN_LOAD, BTN_CLEAR, BTN_START};
    assign w_evt   = r_deb & ~r_deb_d;
    assign w_start = w_evt[0];
    assign w_clear = w_evt[1];
    assign w_load  = w_evt[2];

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES samples in a row.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_deb   <= 3'b000;
            r_deb_d <= 3'b000;
            r_cnt   <= '0;
        end else begin
            r_deb_d <= r_deb;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_deb[i] <= r_sync2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-state, count, prescaler and direction logic; CLEAR beats START beats LOAD.
    always_comb begin
        w_state_nx = r_state;
        w_num_nx   = r_num;
        w_pre_nx   = r_pre;
        w_dir_nx   = r_dir;
        w_step     = r_dir ? bcd_inc(r_num) : bcd_dec(r_num);
        w_tick     = (r_pre == PRE_LAST);
        w_term_hit = r_dir ? (w_step == 8'h99) : (w_step == 8'h00);
        case (r_state)
            ST_IDLE: begin
                if (w_clear) begin
                    w_num_nx = 8'h00;
                end else if (w_start) begin
                    w_dir_nx = UP_DOWN;
                    w_pre_nx = '0;
                    if ((UP_DOWN && (r_num == 8'h99)) || (!UP_DOWN && (r_num == 8'h00))) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end else if (w_load) begin
                    w_num_nx = bcd_clamp(PRESET);
                end else begin
                    w_num_nx = r_num;
                end
            end
            ST_RUN: begin
                if (w_clear) begin
                    w_num_nx   = 8'h00;
                    w_pre_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else if (w_start) begin
                    w_state_nx = ST_PAUSE;
                end else if (w_tick) begin
                    w_pre_nx = '0;
                    w_num_nx = w_step;
                    if (w_term_hit) begin
                        w_state_nx = ST_DONE;
                    end else begin
                        w_state_nx = ST_RUN;
                    end
                end else begin
                    w_pre_nx = r_pre + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (w_clear) begin
                    w_num_nx   = 8'h00;
                    w_pre_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else if (w_start) begin
                    w_state_nx = ST_RUN;
                end else begin
                    w_state_nx = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (w_clear) begin
                    w_num_nx   = 8'h00;
                    w_pre_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else if (w_start) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_DONE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_num_nx   = 8'h00;
                w_pre_nx   = '0;
            end
        endcase
    end

    // State, datapath and registered status decodes.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            r_state   <= ST_IDLE;
            r_num     <= 8'h00;
            r_pre     <= '0;
            r_dir     <= 1'b1;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_num     <= w_num_nx;
            r_pre     <= w_pre_nx;
            r_dir     <= w_dir_nx;
            r_running <= (w_state_nx == ST_RUN);
            r_done    <= (w_state_nx == ST_DONE);
        end
    end

    assign num     = r_num;
    assign RUNNING = r_running;
    assign DONE    = r_done;

endmodule

// File: tb/tb_bcd_timer_control.sv
// Directed bench for bcd_timer_control (CLOCKS_PER_TICK=4, DEBOUNCE_CYCLES=2).
`timescale 1ns/1ps

module tb_bcd_timer_control;

    logic       CLOCK;
    logic       RESET;
    logic       BTN_START;
    logic       BTN_CLEAR;
    logic       BTN_LOAD;
    logic       UP_DOWN;
    logic [7:0] PRESET;
    logic [7:0] num;
    logic       RUNNING;
    logic       DONE;

    int n_total = 0;
    int n_pass  = 0;

    bcd_timer_control #(
        .CLOCKS_PER_TICK(4),
        .DEBOUNCE_CYCLES(2)
    ) dut (
        .CLOCK    (CLOCK),
        .RESET    (RESET),
        .BTN_START(BTN_START),
        .BTN_CLEAR(BTN_CLEAR),
        .BTN_LOAD (BTN_LOAD),
        .UP_DOWN  (UP_DOWN),
        .PRESET   (PRESET),
        .num      (num),
        .RUNNING  (RUNNING),
        .DONE     (DONE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_st(input string tag, input logic [7:0] e_num, input logic e_run, input logic e_done);
        chk({tag, "_num"}, num, e_num);
        chk({tag, "_run"}, {7'd0, RUNNING}, {7'd0, e_run});
        chk({tag, "_done"}, {7'd0, DONE}, {7'd0, e_done});
    endtask

    // m = {load, clear, start}; the FSM acts on the 5th rising edge after the raw rise.
    task automatic press(input logic [2:0] m);
        @(negedge CLOCK);
        BTN_START = m[0];
        BTN_CLEAR = m[1];
        BTN_LOAD  = m[2];
        repeat (5) @(posedge CLOCK);
        #1;
        BTN_START = 1'b0;
        BTN_CLEAR = 1'b0;
        BTN_LOAD  = 1'b0;
    endtask

    task automatic cool();
        repeat (6) @(posedge CLOCK);
        #1;
    endtask

    initial begin
        logic [7:0] e;
        RESET = 1'b1; BTN_START = 1'b0; BTN_CLEAR = 1'b0; BTN_LOAD = 1'b0;
        UP_DOWN = 1'b0; PRESET = 8'h00;
        #1;
        chk_st("reset", 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b0;
        cool();

        // preset clamping
        PRESET = 8'hA5; press(3'b100); chk("clamp_a5", num, 8'h95); cool();
        PRESET = 8'h3C; press(3'b100); chk("clamp_3c", num, 8'h39); cool();

        // one-cycle glitch is filtered
        @(negedge CLOCK); BTN_START = 1'b1;
        @(negedge CLOCK); BTN_START = 1'b0;
        repeat (10) @(posedge CLOCK);
        #1;
        chk_st("glitch", 8'h39, 1'b0, 1'b0);

        // clean press latency: RUN on 5th edge, not 4th
        UP_DOWN = 1'b0;
        @(negedge CLOCK); BTN_START = 1'b1;
        repeat (4) @(posedge CLOCK);
        #1;
        chk("lat_edge4_run", {7'd0, RUNNING}, 8'd0);
        @(posedge CLOCK);
        #1;
        chk("lat_edge5_run", {7'd0, RUNNING}, 8'd1);
        BTN_START = 1'b0;
        press(3'b010);
        chk_st("clear_run", 8'h00, 1'b0, 1'b0);
        cool();

        // load 12 and count down to 00
        PRESET = 8'h12; press(3'b100); chk("load_12", num, 8'h12); cool();
        UP_DOWN = 1'b0;
        press(3'b001);
        chk_st("dn_start", 8'h12, 1'b1, 1'b0);
        for (int i = 1; i <= 12; i++) begin
            repeat (4) @(posedge CLOCK);
            #1;
            e = 8'((((12 - i) / 10) << 4) | ((12 - i) % 10));
            chk_st($sformatf("dn_step%0d", i), e, (i != 12), (i == 12));
        end
        repeat (8) @(posedge CLOCK);
        #1;
        chk_st("dn_hold", 8'h00, 1'b0, 1'b1);
        press(3'b001);
        chk_st("done_ack", 8'h00, 1'b0, 1'b0);
        cool();

        // START at terminal count goes straight to DONE
        UP_DOWN = 1'b0;
        press(3'b001);
        chk_st("term_start", 8'h00, 1'b0, 1'b1);
        cool();
        press(3'b001);
        chk_st("term_ack", 8'h00, 1'b0, 1'b0);
        cool();

        // carry 09 -> 10
        PRESET = 8'h09; press(3'b100); cool();
        UP_DOWN = 1'b1; press(3'b001);
        repeat (4) @(posedge CLOCK);
        #1;
        chk_st("carry", 8'h10, 1'b1, 1'b0);
        press(3'b010);
        chk_st("carry_clr", 8'h00, 1'b0, 1'b0);
        cool();

        // borrow 10 -> 09
        PRESET = 8'h10; press(3'b100); cool();
        UP_DOWN = 1'b0; press(3'b001);
        repeat (4) @(posedge CLOCK);
        #1;
        chk_st("borrow", 8'h09, 1'b1, 1'b0);
        press(3'b010);
        cool();

        // up terminal 98 -> 99
        PRESET = 8'h98; press(3'b100); cool();
        UP_DOWN = 1'b1; press(3'b001);
        repeat (4) @(posedge CLOCK);
        #1;
        chk_st("up_term", 8'h99, 1'b0, 1'b1);
        repeat (8) @(posedge CLOCK);
        #1;
        chk_st("up_hold", 8'h99, 1'b0, 1'b1);
        press(3'b001);
        chk_st("up_ack", 8'h99, 1'b0, 1'b0);
        cool();

        // pause / resume from 50 down; UP_DOWN change while running is ignored
        PRESET = 8'h50; press(3'b100); cool();
        UP_DOWN = 1'b0; press(3'b001);
        UP_DOWN = 1'b1;
        repeat (4) @(posedge CLOCK);
        #1;
        chk("pr_first", num, 8'h49);
        repeat (2) @(posedge CLOCK);
        press(3'b001);
        chk_st("pause", 8'h48, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLOCK);
            #1;
            chk("pause_hold", num, 8'h48);
        end
        press(3'b001);
        chk_st("resume", 8'h48, 1'b1, 1'b0);
        @(posedge CLOCK);
        #1;
        chk("resume_p3", num, 8'h48);
        @(posedge CLOCK);
        #1;
        chk("resume_step", num, 8'h47);

        // LOAD ignored while running
        PRESET = 8'h12;
        press(3'b100);
        chk_st("load_in_run", 8'h46, 1'b1, 1'b0);

        // CLEAR and START together: CLEAR wins
        press(3'b011);
        chk_st("clr_start", 8'h00, 1'b0, 1'b0);
        cool();

        // async reset mid-run at 37
        PRESET = 8'h37; press(3'b100); cool();
        UP_DOWN = 1'b1; press(3'b001);
        chk_st("rst_pre", 8'h37, 1'b1, 1'b0);
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        chk_st("rst_async", 8'h00, 1'b0, 1'b0);
        @(negedge CLOCK);
        RESET = 1'b0;
        repeat (10) @(posedge CLOCK);
        #1;
        chk_st("rst_after", 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
